// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard unit: instruction fields, opcodes, register and pipe masks.
// Pipe mask bit order is PC, IF/ID, ID/EX from LSB. Register field order is RS, RT, RD.
package hazard_scoreboard_pkg;
  localparam int INST_WIDTH         = 32;
  localparam int OPC_W              = 6;
  localparam int OPC_LSB            = 26;
  localparam int REG_FIELD_W        = 5;
  localparam int NUM_REG_FIELDS     = 3;
  localparam int NUM_PIPE_MASKS     = 3;
  localparam int HAZARD_MAX_LATENCY = 7;

  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC    = 3'b001;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID = 3'b010;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX = 3'b100;

  localparam logic [NUM_REG_FIELDS-1:0] REG_MASK_NONE = 3'b000;
  localparam logic [NUM_REG_FIELDS-1:0] REG_MASK_RS   = 3'b001;
  localparam logic [NUM_REG_FIELDS-1:0] REG_MASK_RT   = 3'b010;
  localparam logic [NUM_REG_FIELDS-1:0] REG_MASK_RD   = 3'b100;

  // 00xxxx is the register ALU class, 01xxxx the immediate ALU class, 11xxxx is reserved.
  localparam logic [OPC_W-1:0] OP_CODE_ALU_R = 6'b00_0000;
  localparam logic [OPC_W-1:0] OP_CODE_ALU_I = 6'b01_0000;
  localparam logic [OPC_W-1:0] OP_CODE_NOP   = 6'b10_0000;
  localparam logic [OPC_W-1:0] OP_CODE_JR    = 6'b10_0001;
  localparam logic [OPC_W-1:0] OP_CODE_LW    = 6'b10_0010;
  localparam logic [OPC_W-1:0] OP_CODE_SW    = 6'b10_0011;
  localparam logic [OPC_W-1:0] OP_CODE_LA    = 6'b10_0100;
  localparam logic [OPC_W-1:0] OP_CODE_SA    = 6'b10_0101;

  typedef struct packed {
    logic [NUM_REG_FIELDS-1:0] src;
    logic [NUM_REG_FIELDS-1:0] dst;
    logic                      is_load;
  } slot_mask_t;

  function automatic logic [REG_FIELD_W-1:0] reg_field(input logic [INST_WIDTH-1:0] ins,
                                                       input int f);
    return ins[21 - f*REG_FIELD_W +: REG_FIELD_W];
  endfunction
endpackage

// File: rtl/hazard_scoreboard_reg_mask_decode.sv
// Opcode to source/destination register-field masks for one bundle slot; purely combinational.
// Invalid slots decode to empty masks so they never take part in hazard checks.
module reg_mask_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             slot_vld,
  output slot_mask_t       mask
);

  always_comb begin
    mask = '0;
    if (slot_vld) begin
      case (opcode[5:4])
        2'b00: begin
          mask.src = REG_MASK_RS | REG_MASK_RT;
          mask.dst = REG_MASK_RD;
        end
        2'b01: begin
          mask.src = REG_MASK_RS;
          mask.dst = REG_MASK_RT;
        end
        2'b10: begin
          case (opcode)
            OP_CODE_JR: mask.src = REG_MASK_RS;
            OP_CODE_LW: begin
              mask.src     = REG_MASK_RS;
              mask.dst     = REG_MASK_RT;
              mask.is_load = 1'b1;
            end
            OP_CODE_SW: mask.src = REG_MASK_RS | REG_MASK_RT;
            OP_CODE_LA: mask.dst = REG_MASK_RT;
            OP_CODE_SA: mask.src = REG_MASK_RT;
            default:    mask.dst = REG_MASK_NONE;
          endcase
        end
        default: mask.src = REG_MASK_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// N-wide load-use / intra-bundle hazard unit: combinational issue point and stall/flush masks from a per-register load scoreboard.
// Optional perf counters are built only when HAZARD_PERF_EN is defined; otherwise the counter ports are tied to 0.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ISSUE_WIDTH  = 2,
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [ISSUE_WIDTH*INST_WIDTH-1:0]        instr,
  input  logic [ISSUE_WIDTH-1:0]                   instr_valid,
  input  logic                                     kill,
  output logic [ISSUE_WIDTH-1:0]                   issue_mask,
  output logic [ISSUE_WIDTH*NUM_PIPE_MASKS-1:0]    stall,
  output logic [ISSUE_WIDTH*NUM_PIPE_MASKS-1:0]    flush,
  output logic [31:0]                              load_stall_cnt,
  output logic [31:0]                              split_stall_cnt
);

  slot_mask_t             slot_mask [ISSUE_WIDTH];
  logic [REG_FIELD_W-1:0] regs      [ISSUE_WIDTH][NUM_REG_FIELDS];
  logic [CNT_W-1:0]       cnt_q     [NUM_REGS];
  logic [CNT_W-1:0]       cnt_d     [NUM_REGS];
  logic [ISSUE_WIDTH-1:0] hazard;
  logic [ISSUE_WIDTH-1:0] issue_ok;
  logic                   blocked;
  logic                   unused_ins;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_dec
    reg_mask_decode u_dec (
      .opcode   (instr[i*INST_WIDTH + OPC_LSB +: OPC_W]),
      .slot_vld (instr_valid[i]),
      .mask     (slot_mask[i])
    );
  end

  always_comb begin
    unused_ins = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      unused_ins = unused_ins ^ (^instr[k*INST_WIDTH +: 11]);
      for (int f = 0; f < NUM_REG_FIELDS; f++) begin
        regs[k][f] = reg_field(instr[k*INST_WIDTH +: INST_WIDTH], f);
      end
    end
  end

  // A field that is a source or destination hazards against the scoreboard and against any older slot's destination.
  always_comb begin
    hazard = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int f = 0; f < NUM_REG_FIELDS; f++) begin
        if ((slot_mask[k].src[f] || slot_mask[k].dst[f]) && regs[k][f] != '0) begin
          if (cnt_q[regs[k][f]] != '0) hazard[k] = 1'b1;
          for (int j = 0; j < k; j++) begin
            for (int g = 0; g < NUM_REG_FIELDS; g++) begin
              if (slot_mask[j].dst[g] && regs[j][g] == regs[k][f]) hazard[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    blocked  = 1'b0;
    issue_ok = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      blocked     = blocked | hazard[k];
      issue_ok[k] = !blocked;
    end
    issue_mask = kill ? '0 : (issue_ok & instr_valid);
    stall = '0;
    flush = '0;
    if (!kill && (|hazard)) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        stall[k*NUM_PIPE_MASKS +: NUM_PIPE_MASKS] = issue_ok[k] ? PIPE_REG_PC
                                                               : (PIPE_REG_PC | PIPE_REG_IF_ID);
        flush[k*NUM_PIPE_MASKS +: NUM_PIPE_MASKS] = issue_ok[k] ? PIPE_REG_IF_ID : PIPE_REG_ID_EX;
      end
    end
  end

  // A freshly issued load overrides the decrement of the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    end
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (issue_mask[k] && slot_mask[k].is_load && regs[k][1] != '0) begin
        cnt_d[regs[k][1]] = CNT_W'(LOAD_LATENCY);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] load_stall_cnt_q, load_stall_cnt_d;
  logic [31:0] split_stall_cnt_q, split_stall_cnt_d;

  always_comb begin
    load_stall_cnt_d  = load_stall_cnt_q;
    split_stall_cnt_d = split_stall_cnt_q;
    if (!kill && hazard[0] && instr_valid[0] && load_stall_cnt_q != '1) begin
      load_stall_cnt_d = load_stall_cnt_q + 32'd1;
    end
    if (!kill && !hazard[0] && (|hazard) && split_stall_cnt_q != '1) begin
      split_stall_cnt_d = split_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_stall_cnt_q  <= '0;
      split_stall_cnt_q <= '0;
    end else begin
      load_stall_cnt_q  <= load_stall_cnt_d;
      split_stall_cnt_q <= split_stall_cnt_d;
    end
  end

  assign load_stall_cnt  = load_stall_cnt_q;
  assign split_stall_cnt = split_stall_cnt_q;
`else
  assign load_stall_cnt  = '0;
  assign split_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (load latency 1 and 3) share stimulus; checked by directed tables and a ready-time model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam logic [5:0] OP_ADD  = 6'b00_0000;
  localparam logic [5:0] OP_SUB  = 6'b00_0010;
  localparam logic [5:0] OP_ADDI = 6'b01_0000;
  localparam logic [5:0] OP_RSV  = 6'b11_0011;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instr;
  logic [1:0]  instr_valid;
  logic        kill;
  logic [1:0]  iss1, iss3;
  logic [5:0]  stl1, stl3, fls1, fls3;
  logic [31:0] lsc1, lsc3, ssc1, ssc3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready [2][32];
  int lat [2] = '{1, 3};
  int mlsc [2];
  int mssc [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.ISSUE_WIDTH(2), .NUM_REGS(32), .LOAD_LATENCY(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .kill(kill),
    .issue_mask(iss1), .stall(stl1), .flush(fls1),
    .load_stall_cnt(lsc1), .split_stall_cnt(ssc1));

  hazard_scoreboard #(.ISSUE_WIDTH(2), .NUM_REGS(32), .LOAD_LATENCY(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .kill(kill),
    .issue_mask(iss3), .stall(stl3), .flush(fls3),
    .load_stall_cnt(lsc3), .split_stall_cnt(ssc3));

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'h0};
  endfunction

  function automatic logic [63:0] b2(input logic [31:0] s0, input logic [31:0] s1);
    return {s1, s0};
  endfunction

  // Register sets read and written by one instruction, as bitmaps over the register file.
  function automatic logic [31:0] reads(input logic [31:0] i, input logic v);
    logic [5:0]  op;
    logic [31:0] rs, rt;
    op = i[31:26];
    rs = 32'h1 << i[25:21];
    rt = 32'h1 << i[20:16];
    if (!v) return 32'h0;
    if (op[5:4] == 2'b00) return rs | rt;
    if (op[5:4] == 2'b01) return rs;
    if (op == OP_CODE_JR || op == OP_CODE_LW) return rs;
    if (op == OP_CODE_SW) return rs | rt;
    if (op == OP_CODE_SA) return rt;
    return 32'h0;
  endfunction

  function automatic logic [31:0] writes(input logic [31:0] i, input logic v);
    logic [5:0] op;
    op = i[31:26];
    if (!v) return 32'h0;
    if (op[5:4] == 2'b00) return 32'h1 << i[15:11];
    if (op[5:4] == 2'b01 || op == OP_CODE_LW || op == OP_CODE_LA) return 32'h1 << i[20:16];
    return 32'h0;
  endfunction

  function automatic int hpoint(input int m);
    logic [31:0] pend, older, use_set, ins;
    int h;
    pend = 32'h0;
    for (int r = 1; r < 32; r++) if (cyc < ready[m][r]) pend[r] = 1'b1;
    older = 32'h0;
    h = 2;
    for (int k = 0; k < 2; k++) begin
      ins = instr[k*32 +: 32];
      use_set = (reads(ins, instr_valid[k]) | writes(ins, instr_valid[k])) & 32'hFFFF_FFFE;
      if (h == 2 && (use_set & (pend | older)) != 0) h = k;
      older |= writes(ins, instr_valid[k]);
    end
    return h;
  endfunction

  function automatic logic [1:0] exp_iss(input int h);
    logic [1:0] e;
    e = 2'b00;
    for (int k = 0; k < 2; k++) if (k < h && instr_valid[k] && !kill) e[k] = 1'b1;
    return e;
  endfunction

  function automatic logic [5:0] exp_mask(input int h, input bit is_flush);
    logic [5:0] e;
    e = 6'h0;
    if (!kill && h < 2) begin
      for (int k = 0; k < 2; k++) begin
        if (k < h) e[k*3 +: 3] = is_flush ? 3'b010 : 3'b001;
        else       e[k*3 +: 3] = is_flush ? 3'b100 : 3'b011;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] perf_exp(input int v);
    return PERF ? 32'(v) : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int h;
    h = hpoint(0);
    chk({tag, " iss1"}, 64'(iss1), 64'(exp_iss(h)));
    chk({tag, " stall1"}, 64'(stl1), 64'(exp_mask(h, 1'b0)));
    chk({tag, " flush1"}, 64'(fls1), 64'(exp_mask(h, 1'b1)));
    chk({tag, " lsc1"}, 64'(lsc1), 64'(perf_exp(mlsc[0])));
    chk({tag, " ssc1"}, 64'(ssc1), 64'(perf_exp(mssc[0])));
    h = hpoint(1);
    chk({tag, " iss3"}, 64'(iss3), 64'(exp_iss(h)));
    chk({tag, " stall3"}, 64'(stl3), 64'(exp_mask(h, 1'b0)));
    chk({tag, " flush3"}, 64'(fls3), 64'(exp_mask(h, 1'b1)));
    chk({tag, " lsc3"}, 64'(lsc3), 64'(perf_exp(mlsc[1])));
    chk({tag, " ssc3"}, 64'(ssc3), 64'(perf_exp(mssc[1])));
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) ready[m][r] = 0;
      mlsc[m] = 0;
      mssc[m] = 0;
    end
  endtask

  task automatic drive(input logic [63:0] b, input logic [1:0] v, input logic k);
    @(negedge clk);
    instr = b;
    instr_valid = v;
    kill = k;
    #1;
  endtask

  // Advance the model across the next rising edge: a load issued now is usable from cyc+lat+1.
  task automatic tick();
    int h;
    logic [1:0] ie;
    logic [31:0] ins;
    for (int m = 0; m < 2; m++) begin
      h = hpoint(m);
      ie = exp_iss(h);
      if (!kill && h == 0 && instr_valid[0]) mlsc[m]++;
      if (!kill && h == 1) mssc[m]++;
      for (int k = 0; k < 2; k++) begin
        ins = instr[k*32 +: 32];
        if (ie[k] && ins[31:26] == OP_CODE_LW && ins[20:16] != 5'd0)
          ready[m][ins[20:16]] = cyc + 1 + lat[m];
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [5:0] op;
    case ($urandom_range(0, 12))
      0, 1, 2, 3: op = OP_CODE_LW;
      4:  op = OP_ADD;
      5:  op = OP_SUB;
      6:  op = OP_ADDI;
      7:  op = OP_CODE_SW;
      8:  op = OP_CODE_LA;
      9:  op = OP_CODE_SA;
      10: op = OP_CODE_JR;
      11: op = OP_CODE_NOP;
      default: op = OP_RSV;
    endcase
    return ri(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endfunction

  typedef struct {
    logic [63:0] ins;
    logic [1:0]  vld;
    logic        kl;
    logic [1:0]  e1;
    logic [1:0]  e3;
    logic [5:0]  st1;
    logic [5:0]  fl1;
  } vec_t;

  vec_t tv [14];

  initial begin
    logic [31:0] nop, cons;
    nop = ri(OP_CODE_NOP, 0, 0, 0);
    tv[0]  = '{b2(ri(OP_CODE_LW, 1, 5, 0), ri(OP_ADD, 1, 2, 7)), 2'b11, 1'b0, 2'b11, 2'b11, 6'o00, 6'o00};
    tv[1]  = '{b2(ri(OP_ADD, 5, 1, 8), ri(OP_ADD, 2, 3, 9)), 2'b11, 1'b0, 2'b00, 2'b00, 6'o33, 6'o44};
    tv[2]  = '{b2(ri(OP_ADD, 5, 1, 8), ri(OP_ADD, 2, 3, 9)), 2'b11, 1'b0, 2'b11, 2'b00, 6'o00, 6'o00};
    tv[3]  = '{b2(ri(OP_ADD, 5, 1, 8), ri(OP_ADD, 2, 3, 9)), 2'b11, 1'b0, 2'b11, 2'b00, 6'o00, 6'o00};
    tv[4]  = '{b2(ri(OP_ADD, 5, 1, 8), ri(OP_ADD, 2, 3, 9)), 2'b11, 1'b0, 2'b11, 2'b11, 6'o00, 6'o00};
    tv[5]  = '{b2(ri(OP_ADDI, 1, 3, 0), ri(OP_SUB, 3, 2, 6)), 2'b11, 1'b0, 2'b01, 2'b01, 6'o31, 6'o42};
    tv[6]  = '{b2(ri(OP_CODE_LW, 1, 0, 0), ri(OP_ADD, 0, 0, 4)), 2'b11, 1'b0, 2'b11, 2'b11, 6'o00, 6'o00};
    tv[7]  = '{b2(ri(OP_ADD, 0, 0, 1), ri(OP_ADD, 0, 0, 2)), 2'b11, 1'b0, 2'b11, 2'b11, 6'o00, 6'o00};
    tv[8]  = '{b2(ri(OP_ADDI, 1, 10, 0), ri(OP_CODE_LW, 2, 10, 0)), 2'b11, 1'b0, 2'b01, 2'b01, 6'o31, 6'o42};
    tv[9]  = '{b2(ri(OP_CODE_LW, 1, 11, 0), nop), 2'b11, 1'b0, 2'b11, 2'b11, 6'o00, 6'o00};
    tv[10] = '{b2(ri(OP_ADDI, 2, 11, 0), nop), 2'b11, 1'b0, 2'b00, 2'b00, 6'o33, 6'o44};
    tv[11] = '{b2(ri(OP_ADD, 1, 2, 12), ri(OP_ADD, 1, 2, 13)), 2'b11, 1'b1, 2'b00, 2'b00, 6'o00, 6'o00};
    tv[12] = '{b2(ri(OP_ADD, 11, 1, 14), ri(OP_ADD, 1, 2, 15)), 2'b01, 1'b0, 2'b01, 2'b00, 6'o00, 6'o00};
    tv[13] = '{b2(ri(OP_ADD, 11, 1, 14), ri(OP_ADD, 1, 2, 15)), 2'b01, 1'b0, 2'b01, 2'b01, 6'o00, 6'o00};

    reset = 1'b1;
    instr = b2(ri(OP_ADD, 1, 2, 3), ri(OP_ADD, 4, 5, 6));
    instr_valid = 2'b11;
    kill = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    chk("reset iss1", 64'(iss1), 64'(2'b11));
    chk("reset stall3", 64'(stl3), 64'h0);
    check_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].ins, tv[i].vld, tv[i].kl);
      chk($sformatf("vec%0d iss1", i), 64'(iss1), 64'(tv[i].e1));
      chk($sformatf("vec%0d iss3", i), 64'(iss3), 64'(tv[i].e3));
      chk($sformatf("vec%0d stall1", i), 64'(stl1), 64'(tv[i].st1));
      chk($sformatf("vec%0d flush1", i), 64'(fls1), 64'(tv[i].fl1));
      if (i == 4) chk("lat3 load_stall_cnt", 64'(lsc3), 64'(perf_exp(3)));
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Reset while a latency-3 load is still counting down.
    cons = ri(OP_ADD, 9, 1, 10);
    drive(b2(ri(OP_CODE_LW, 1, 9, 0), nop), 2'b01, 1'b0);
    check_all("rst_seq load");
    tick();
    drive(b2(cons, nop), 2'b01, 1'b0);
    chk("rst_seq held t+1", 64'(iss3), 64'(2'b00));
    tick();
    drive(b2(cons, nop), 2'b01, 1'b0);
    chk("rst_seq held t+2", 64'(iss3), 64'(2'b00));
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_seq async clear", 64'(iss3), 64'(2'b01));
    chk("rst_seq perf clear", 64'(lsc3), 64'h0);
    check_all("rst_seq in reset");
    reset = 1'b0;
    #1;
    tick();
    drive(b2(cons, nop), 2'b01, 1'b0);
    chk("rst_seq consumer issues", 64'(iss3), 64'(2'b01));
    chk("rst_seq perf after", 64'(lsc3), 64'h0);
    check_all("rst_seq after");
    tick();

    for (int n = 0; n < 500; n++) begin
      logic [1:0] v;
      v = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      drive(b2(rnd_ins(), rnd_ins()), v, $urandom_range(0, 9) == 0);
      check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        check_all($sformatf("rnd%0d reset", n));
        reset = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
